// File: rtl/register_bank_sb.sv
// register_bank_sb: register file with write enable, zero register, write bypass,
// busy scoreboard and a sequenced bulk-clear engine.
module register_bank_sb #(
    parameter int WIDTH    = 32,
    parameter int ADDR     = 4,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [ADDR-1:0]  dest,
    input  logic [WIDTH-1:0] Din,
    input  logic [ADDR-1:0]  srcadd1,
    input  logic [ADDR-1:0]  srcadd2,
    output logic [WIDTH-1:0] src1,
    output logic [WIDTH-1:0] src2,
    input  logic             rsv,
    input  logic [ADDR-1:0]  rsvadd,
    output logic             busy1,
    output logic             busy2,
    input  logic             clr,
    output logic             clr_busy
);
    localparam int DEPTH = 1 << ADDR;
    localparam bit ZR = ZERO_REG != 0;
    localparam bit BP = BYPASS != 0;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t           state;
    logic [ADDR-1:0]  cnt;
    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] busy;
    logic             wr, rs, fwd1, fwd2, z1, z2;

    // Writes and reservations are only honoured while the clear engine is idle
    assign wr = we && state == IDLE && !(ZR && dest == '0);
    assign rs = rsv && state == IDLE && !(ZR && rsvadd == '0);
    assign clr_busy = state == CLEAR;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= '0;
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (state == IDLE) begin
            if (wr) begin
                regs[dest] <= Din;
                busy[dest] <= 1'b0;
            end
            if (rs) busy[rsvadd] <= 1'b1;
            if (clr) begin
                state <= CLEAR;
                cnt   <= '0;
            end
        end else begin
            regs[cnt] <= '0;
            busy[cnt] <= 1'b0;
            cnt       <= cnt + 1'b1;
            if (cnt == ADDR'(DEPTH - 1)) state <= IDLE;
        end
    end

    always_comb begin
        z1    = ZR && srcadd1 == '0;
        z2    = ZR && srcadd2 == '0;
        fwd1  = BP && wr && dest == srcadd1;
        fwd2  = BP && wr && dest == srcadd2;
        src1  = z1 ? '0 : fwd1 ? Din : regs[srcadd1];
        src2  = z2 ? '0 : fwd2 ? Din : regs[srcadd2];
        busy1 = !(z1 || fwd1) && busy[srcadd1];
        busy2 = !(z2 || fwd2) && busy[srcadd2];
    end
endmodule
